// File: rtl/sw_pkg.sv
// Shared types and encodings for the Smith-Waterman array feeder.
package sw_pkg;

  typedef enum logic [1:0] {
    Q_LOAD = 2'd0,
    Q_FULL = 2'd1,
    Q_HOLD = 2'd2
  } qstate_t;

  typedef enum logic {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rstate_t;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'd0;
  localparam base_t BASE_C = 2'd1;
  localparam base_t BASE_G = 2'd2;
  localparam base_t BASE_T = 2'd3;

endpackage

// File: rtl/sw_done_delay.sv
// DEPTH-deep single-bit shift register; the tail marks a job's last column
// leaving the final PE.
module sw_done_delay #(
  parameter int DEPTH = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic any
);

  logic [DEPTH-1:0] line_q;
  logic [DEPTH-1:0] line_d;

  always_comb begin
    line_d = {line_q[DEPTH-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign dout = line_q[DEPTH-1];
  assign any  = |line_q;

endmodule

// File: rtl/sw_array_feeder.sv
// Drives query shift-in, store, reference and init streams into the systolic
// array. Valid/ready: a transfer happens on a rising edge where valid & ready.
module sw_array_feeder
  import sw_pkg::*;
#(
  parameter int NUM_PES = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       q_valid,
  output logic       q_ready,
  input  logic [1:0] q_base,
  input  logic       t_valid,
  output logic       t_ready,
  input  logic [1:0] t_base,
  input  logic       t_last,
  output logic [1:0] S_out,
  output logic       shift_S,
  output logic       store_S,
  output logic [1:0] T_out,
  output logic       init_out,
  output logic       busy,
  output logic       job_done,
  output logic       underrun,
  output logic [1:0] dbg_qstate,
  output logic       dbg_rstate
);

  localparam int QW = $clog2(NUM_PES + 1);
  localparam int HW = $clog2(NUM_PES);

  qstate_t       qstate_q, qstate_d;
  rstate_t       rstate_q, rstate_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          armed_q, armed_d;
  base_t         s_q, s_d;
  base_t         t_q, t_d;
  logic          shift_q, shift_d;
  logic          store_q, store_d;
  logic          init_q, init_d;
  logic          last_q, last_d;
  logic          underrun_q, underrun_d;
  logic          q_hs, t_hs, job_start;
  logic          dly_any;

  assign q_hs      = q_valid & q_ready;
  assign t_hs      = t_valid & t_ready;
  assign job_start = t_hs & (rstate_q == R_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qstate_q   <= Q_LOAD;
      rstate_q   <= R_IDLE;
      qcnt_q     <= '0;
      hcnt_q     <= '0;
      armed_q    <= 1'b0;
      s_q        <= '0;
      t_q        <= '0;
      shift_q    <= 1'b0;
      store_q    <= 1'b0;
      init_q     <= 1'b0;
      last_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      qstate_q   <= qstate_d;
      rstate_q   <= rstate_d;
      qcnt_q     <= qcnt_d;
      hcnt_q     <= hcnt_d;
      armed_q    <= armed_d;
      s_q        <= s_d;
      t_q        <= t_d;
      shift_q    <= shift_d;
      store_q    <= store_d;
      init_q     <= init_d;
      last_q     <= last_d;
      underrun_q <= underrun_d;
    end
  end

  // The hold lasts NUM_PES-1 cycles so the staged query is latched by every
  // PE before the next one starts shifting in.
  always_comb begin
    qstate_d = qstate_q;
    qcnt_d   = qcnt_q;
    hcnt_d   = hcnt_q;
    case (qstate_q)
      Q_LOAD: begin
        if (q_hs) begin
          qcnt_d = qcnt_q + QW'(1);
          if (qcnt_q == QW'(NUM_PES - 1)) qstate_d = Q_FULL;
        end
      end
      Q_FULL: begin
        if (job_start) begin
          qstate_d = Q_HOLD;
          hcnt_d   = HW'(NUM_PES - 2);
        end
      end
      Q_HOLD: begin
        if (hcnt_q == '0) begin
          qstate_d = Q_LOAD;
          qcnt_d   = '0;
        end else begin
          hcnt_d = hcnt_q - HW'(1);
        end
      end
      default: qstate_d = Q_LOAD;
    endcase
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:   if (t_hs && !t_last) rstate_d = R_STREAM;
      R_STREAM: if (t_hs && t_last) rstate_d = R_IDLE;
      default:  rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    armed_d    = 1'b1;
    q_ready    = armed_q & (qstate_q == Q_LOAD);
    t_ready    = (rstate_q == R_STREAM) | (qstate_q == Q_FULL);
    s_d        = q_hs ? q_base : 2'd0;
    shift_d    = q_hs;
    t_d        = t_hs ? t_base : 2'd0;
    init_d     = t_hs;
    store_d    = job_start;
    last_d     = t_hs & t_last;
    underrun_d = underrun_q | ((rstate_q == R_STREAM) & ~t_valid);
  end

  sw_done_delay #(
    .DEPTH(NUM_PES)
  ) u_done_delay (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (last_q),
    .dout (job_done),
    .any  (dly_any)
  );

  assign S_out      = s_q;
  assign shift_S    = shift_q;
  assign store_S    = store_q;
  assign T_out      = t_q;
  assign init_out   = init_q;
  assign underrun   = underrun_q;
  assign busy       = (rstate_q == R_STREAM) | dly_any | last_q | store_q;
  assign dbg_qstate = qstate_q;
  assign dbg_rstate = rstate_q;

endmodule
